irda_sir_encoder: RTL and testbench
===================================

Name: irda_sir_encoder

Overview:
Downstream stage of the IrDA transmitter. Converts the NRZ serial bit stream from the transmit shift register into IrDA SIR pulses. Each '0' bit becomes a pulse of PULSE_SLOTS/16 of the bit period. Each '1' bit produces no pulse. The block is bit-aligned by the transmitter's bit strobe and times each bit with its own 16x sub-bit counter, which drives the IR LED driver pin.

Parameters:
CLK_DIV, 4, clk cycles per sub-bit slot (1/16 bit period); must be >= 2
DIV_W, 8, width of the prescaler counter; must satisfy 2^DIV_W > CLK_DIV
PULSE_SLOTS, 3, pulse width in slots (3 = IrDA 3/16); legal range 1..15
INVERT, 0, 1 = ir_tx active-low (driver polarity)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  encoder enable; low forces idle
bit_start  in  1  single-cycle strobe marking the start of a bit period; asserted in the same cycle the transmitter loads or shifts
tx_bit  in  1  serial data bit; sampled only on bit_start
ir_tx  out  1  IR pulse output, registered
pulse_active  out  1  high while a pulse is being driven, independent of INVERT
bit_busy  out  1  high while a bit period is being timed
overrun  out  1  sticky: bit_start arrived before the current bit period was nearly complete

Behaviour:
- Reset, and whenever enable=0: state=IDLE, prescaler=0, slot=0, pulse_active=0, bit_busy=0, ir_tx=INVERT. overrun clears only on reset; enable=0 leaves it unchanged.
- Prescaler counts 0..CLK_DIV-1 and wraps. Each wrap is a slot tick, which increments slot (4 bits, 0..15). Both counters run only in PULSE and HOLD.
- States:
  - IDLE: waits for bit_start.
  - PULSE: drives the pulse.
  - HOLD: remainder of the bit period.
- bit_start with enable=1, in any state:
  - latch tx_bit, prescaler<=0, slot<=0, bit_busy<=1
  - next state is PULSE if the latched bit = 0, otherwise HOLD
- PULSE -> HOLD on the slot tick where slot = PULSE_SLOTS-1.
- HOLD -> IDLE on the slot tick where slot = 15. bit_busy drops in the same cycle.
- Latency:
  - bit_start at cycle t gives pulse_active=1 at cycles t+1 .. t+PULSE_SLOTS*CLK_DIV inclusive.
  - bit_busy is high at cycles t+1 .. t+16*CLK_DIV.
- ir_tx = pulse_active XOR INVERT, registered, with no combinational path from inputs.
- Early bit_start (state PULSE or HOLD with slot < 15):
  - overrun<=1
  - the new bit restarts timing immediately, per the bit_start rule above
  - an in-progress pulse is truncated if the new bit is 1, or restarted with full width if the new bit is 0
- bit_start in HOLD with slot = 15, including the final-tick cycle: no overrun. The new bit takes priority over the IDLE transition. For back-to-back bits with a '0' bit, this gives contiguous pulse spacing of 16*CLK_DIV cycles.
- bit_start while enable=0 is ignored. enable falling mid-bit aborts immediately: ir_tx returns to inactive on the next cycle.
- Reset mid-pulse: ir_tx inactive on the next cycle, and all state is cleared.

Test Plan:
1. CLK_DIV=4, PULSE_SLOTS=3, INVERT=0; bit_start with tx_bit=0 at cycle 10 -> ir_tx=1 on cycles 11..22, bit_busy=1 on cycles 11..74, then bit_busy=0 and state IDLE.
2. bit_start with tx_bit=1 -> ir_tx stays 0 throughout; bit_busy=1 for 64 cycles; overrun=0.
3. Byte 0x55 LSB-first with start bit 0 and stop bit 1, bit_start every 64 cycles -> ten bits, pulses at bit positions 0,2,4,6,8, each exactly 12 cycles wide; no overrun.
4. Second bit_start (tx_bit=0) 20 cycles after the first -> overrun=1 and stays 1; a new 12-cycle pulse starts at cycle +21.
5. Reset asserted at the 5th pulse cycle -> ir_tx=0 next cycle, bit_busy=0, overrun=0; a following bit_start then yields a normal 12-cycle pulse.
6. INVERT=1: idle ir_tx=1; a '0' bit drives ir_tx=0 for 12 cycles while pulse_active=1.

Source files
------------

// File: rtl/irda_sir_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : irda_sir_encoder
//  Purpose  : NRZ-to-IrDA SIR pulse encoder, 16 sub-bit slots per bit period.
//  Revision : 1.0 - initial release
// ============================================================================
module irda_sir_encoder #(
  parameter int CLK_DIV     = 4,
  parameter int DIV_W       = 8,
  parameter int PULSE_SLOTS = 3,
  parameter int INVERT      = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic bit_start,
  input  logic tx_bit,
  output logic ir_tx,
  output logic pulse_active,
  output logic bit_busy,
  output logic overrun
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam logic [DIV_W-1:0] C_DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] C_DIV_ONE    = DIV_W'(1);
  localparam logic [3:0]       C_PULSE_LAST = 4'(PULSE_SLOTS - 1);
  localparam logic [3:0]       C_SLOT_LAST  = 4'd15;
  localparam logic             C_IR_IDLE    = (INVERT != 0);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [3:0]       slot_q,  slot_d;
  logic             pulse_q, pulse_d;
  logic             busy_q,  busy_d;
  logic             ir_q,    ir_d;
  logic             ovr_q,   ovr_d;

  logic             w_tick;
  logic             w_early;

  assign w_tick  = (state_q != ST_IDLE) && (presc_q == C_DIV_LAST);
  // The last slot of HOLD is the legal window for the next bit_start.
  assign w_early = (state_q == ST_PULSE) ||
                   ((state_q == ST_HOLD) && (slot_q != C_SLOT_LAST));

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    slot_d  = slot_q;
    ovr_d   = ovr_q;

    if (!enable) begin
      state_d = ST_IDLE;
      presc_d = '0;
      slot_d  = '0;
    end else if (bit_start) begin
      if (w_early) begin
        ovr_d = 1'b1;
      end
      state_d = tx_bit ? ST_HOLD : ST_PULSE;
      presc_d = '0;
      slot_d  = '0;
    end else if (state_q != ST_IDLE) begin
      if (w_tick) begin
        presc_d = '0;
        slot_d  = slot_q + 4'd1;
        if ((state_q == ST_PULSE) && (slot_q == C_PULSE_LAST)) begin
          state_d = ST_HOLD;
        end else if ((state_q == ST_HOLD) && (slot_q == C_SLOT_LAST)) begin
          state_d = ST_IDLE;
        end
      end else begin
        presc_d = presc_q + C_DIV_ONE;
      end
    end

    pulse_d = (state_d == ST_PULSE);
    busy_d  = (state_d != ST_IDLE);
    ir_d    = pulse_d ^ C_IR_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      slot_q  <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      ir_q    <= C_IR_IDLE;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      slot_q  <= slot_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      ir_q    <= ir_d;
      ovr_q   <= ovr_d;
    end
  end

  assign ir_tx        = ir_q;
  assign pulse_active = pulse_q;
  assign bit_busy     = busy_q;
  assign overrun      = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_irda_sir_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irda_sir_encoder
//  Purpose  : Scoreboard bench for irda_sir_encoder, normal and inverted polarity.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_irda_sir_encoder;

  localparam int CD = 4;
  localparam int PS = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic bit_start = 1'b0;
  logic tx_bit = 1'b0;
  logic ir0, pa0, busy0, ovr0;
  logic ir1, pa1, busy1, ovr1;

  always #5 clk = ~clk;

  irda_sir_encoder #(.CLK_DIV(CD), .DIV_W(8), .PULSE_SLOTS(PS), .INVERT(0)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .bit_start(bit_start), .tx_bit(tx_bit),
    .ir_tx(ir0), .pulse_active(pa0), .bit_busy(busy0), .overrun(ovr0)
  );

  irda_sir_encoder #(.CLK_DIV(CD), .DIV_W(8), .PULSE_SLOTS(PS), .INVERT(1)) u_dut_inv (
    .clk(clk), .reset(reset), .enable(enable), .bit_start(bit_start), .tx_bit(tx_bit),
    .ir_tx(ir1), .pulse_active(pa1), .bit_busy(busy1), .overrun(ovr1)
  );

  typedef struct {
    logic rst;
    logic en;
    logic bs;
    logic b;
    int   idle;
  } vec_t;

  typedef logic [7:0] exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Expected behaviour in terms of absolute cycles of the last accepted bit
  int   m_start = -1000;
  int   m_pend  = -1;
  int   m_bend  = -1;
  logic m_ovr   = 1'b0;

  int   pulses  = 0;
  int   hi_cyc  = 0;
  logic prev_ir = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic s, input logic b);
    exp_t ex;
    exp_t act;
    logic pa;
    logic bz;
    @(negedge clk);
    if (sb_q.size() > 0) begin
      ex  = sb_q.pop_front();
      act = {ir0, pa0, busy0, ovr0, ir1, pa1, busy1, ovr1};
      total++;
      if (act !== ex) begin
        bad++;
        $display("FAIL outputs cycle %0d {ir,pa,busy,ovr,ir_inv,pa_inv,busy_inv,ovr_inv}: got %b expected %b",
                 cyc, act, ex);
      end
    end
    if (ir0 === 1'b1 && prev_ir !== 1'b1) pulses++;
    if (ir0 === 1'b1) hi_cyc++;
    prev_ir = ir0;

    reset = r; enable = e; bit_start = s; tx_bit = b;

    if (r) begin
      m_pend = -1; m_bend = -1; m_ovr = 1'b0;
    end else if (!e) begin
      m_pend = -1; m_bend = -1;
    end else if (s) begin
      // Early unless the previous bit has reached its final slot
      if (m_bend >= cyc && cyc < m_start + 1 + 15 * CD) m_ovr = 1'b1;
      m_start = cyc;
      m_bend  = cyc + 16 * CD;
      m_pend  = b ? cyc : cyc + PS * CD;
    end
    pa = (cyc + 1 > m_start) && (cyc + 1 <= m_pend);
    bz = (cyc + 1 > m_start) && (cyc + 1 <= m_bend);
    sb_q.push_back({pa, pa, bz, m_ovr, ~pa, pa, bz, m_ovr});
    cyc++;
  endtask

  task automatic run(input vec_t v);
    step(v.rst, v.en, v.bs, v.b);
    for (int k = 0; k < v.idle; k++) step(1'b0, v.en, 1'b0, 1'b0);
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    logic [9:0] frame;

    // reset, single '0', single '1', final-slot restart, one-slot-early restart
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 5});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 80});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 80});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 62});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 80});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 59});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 80});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 5});
    foreach (tbl[i]) run(tbl[i]);
    check("overrun_after_early_start", int'(ovr0), 0);

    // 0x55 LSB-first framed with start 0 and stop 1
    frame = {1'b1, 8'h55, 1'b0};
    pulses = 0; hi_cyc = 0;
    for (int i = 0; i < 10; i++) begin
      v = '{1'b0, 1'b1, 1'b1, frame[i], (i == 9) ? 80 : 63};
      run(v);
    end
    check("byte_pulse_count", pulses, 5);
    check("byte_pulse_cycles", hi_cyc, 5 * PS * CD);
    check("byte_no_overrun", int'(ovr0), 0);

    // second '0' 20 cycles after the first, then disable mid-bit
    run('{1'b0, 1'b1, 1'b1, 1'b0, 19});
    run('{1'b0, 1'b1, 1'b1, 1'b0, 80});
    check("overrun_sticky", int'(ovr0), 1);
    run('{1'b0, 1'b1, 1'b1, 1'b0, 5});
    run('{1'b0, 1'b0, 1'b0, 1'b0, 3});
    run('{1'b0, 1'b0, 1'b1, 1'b0, 3});
    run('{1'b0, 1'b1, 1'b0, 1'b0, 3});
    check("overrun_kept_while_disabled", int'(ovr0), 1);

    // reset on the fifth pulse cycle, then a normal bit
    run('{1'b0, 1'b1, 1'b1, 1'b0, 4});
    check("pulse_before_reset", int'(ir0), 1);
    run('{1'b1, 1'b1, 1'b0, 1'b0, 5});
    check("overrun_cleared_by_reset", int'(ovr0), 0);
    pulses = 0; hi_cyc = 0;
    run('{1'b0, 1'b1, 1'b1, 1'b0, 80});
    check("pulse_after_reset", hi_cyc, PS * CD);
    check("inverted_idle_level", int'(ir1), 1);
    step(1'b0, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
